// File: rtl/calc3_pkg.sv
// calc3_pkg: shared encodings for the calc3 result-retirement stage.
//   - cmd_e        : ALU command codes that produce a response
//   - resp_e       : per-port response codes
//   - resp_entry_t : response-entry layout {resp, tag, data}; the field widths
//                    here are the default configuration, and the stage uses a
//                    parametrised struct with the same field order
//   - is_arith / is_branch : command classification helpers
package calc3_pkg;

  typedef enum logic [3:0] {
    CMD_ADD = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_BZ  = 4'b1100,
    CMD_BEQ = 4'b1101
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_OVFL = 2'b10,
    RESP_SKIP = 2'b11
  } resp_e;

  localparam int unsigned DEF_TAG_BITS = 2;
  localparam int unsigned DEF_DATA_W   = 32;

  typedef struct packed {
    resp_e                   resp;
    logic [DEF_TAG_BITS-1:0] tag;
    logic [DEF_DATA_W-1:0]   data;
  } resp_entry_t;

  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  function automatic logic is_branch(input logic [3:0] cmd);
    return (cmd == CMD_BZ) || (cmd == CMD_BEQ);
  endfunction

endpackage

// File: rtl/calc_out_fifo.sv
// calc_out_fifo: synchronous response FIFO for one requester port.
//   c_clk     : clock, state updates on the falling edge
//   reset     : asynchronous, active-high; empties the FIFO
//   push      : write push_data (ignored when full)
//   push_data : entry to enqueue
//   pop       : drop the head entry (ignored when empty)
//   full      : occupancy == DEPTH (independent of a same-cycle pop)
//   valid     : FIFO holds at least one entry
//   head      : oldest entry, all zeros while empty
module calc_out_fifo #(
  parameter  int unsigned WIDTH = 36,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign valid   = (count_q != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign head    = valid ? mem_q[rd_ptr_q] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(negedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(negedge c_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/calc_output_stage.sv
// calc_output_stage: retires one completed calc3 ALU command per cycle.
// Classifies add/sub, branch, skipped and invalid commands, updates the
// branch-condition table, issues the register-file write and queues the
// response into the per-port FIFO selected by the upper tag bits.
// Ports (vectors are [0:N-1], index 0 = MSB):
//   c_clk, reset            : falling-edge clock, async active-high reset
//   in_valid/in_ready       : command handshake; ready = target FIFO not full
//   in_cmd, in_tag          : command code, {port, tag}
//   in_result               : {carry/borrow, result}
//   in_result_reg           : {write enable, register address}
//   in_follow_branch        : {dependent flag, governing branch tag}
//   write_valid/adr/data    : registered register-file write
//   branch_data             : branch table, entry t at index t
//   out_valid/out_ack       : per-port response handshake
//   out_resp/out_tag/out_data : per-port FIFO head, port p at slice p*W
// Optional: `define CALC_OUT_OVFL_CNT_EN adds ovfl_count, a saturating
// count of accepted overflow responses.
module calc_output_stage
  import calc3_pkg::*;
#(
  parameter  int unsigned NUM_PORTS  = 4,
  parameter  int unsigned TAG_BITS   = 2,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned REG_ADR_W  = 4,
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PORT_BITS  = $clog2(NUM_PORTS),
  localparam int unsigned FT         = PORT_BITS + TAG_BITS,
  localparam int unsigned NUM_TAGS   = 1 << FT
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:3]                    in_cmd,
  input  logic [0:FT-1]                 in_tag,
  input  logic [0:DATA_W]               in_result,
  input  logic [0:REG_ADR_W]            in_result_reg,
  input  logic [0:FT]                   in_follow_branch,
  output logic                          write_valid,
  output logic [0:REG_ADR_W-1]          write_adr,
  output logic [0:DATA_W-1]             write_data,
  output logic [0:NUM_TAGS-1]           branch_data,
  output logic [0:NUM_PORTS-1]          out_valid,
  input  logic [0:NUM_PORTS-1]          out_ack,
  output logic [0:2*NUM_PORTS-1]        out_resp,
  output logic [0:TAG_BITS*NUM_PORTS-1] out_tag,
  output logic [0:DATA_W*NUM_PORTS-1]   out_data
`ifdef CALC_OUT_OVFL_CNT_EN
  ,
  output logic [0:7]                    ovfl_count
`endif
);

  typedef struct packed {
    resp_e               resp;
    logic [TAG_BITS-1:0] tag;
    logic [DATA_W-1:0]   data;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  logic [PORT_BITS-1:0] port_sel;
  logic [FT-1:0]        tag_idx, follow_idx;
  logic [DATA_W-1:0]    result;
  logic                 carry, skip, taken, accept, cmd_arith, cmd_branch;
  logic [NUM_PORTS-1:0] fifo_full, fifo_valid;
  logic [EW-1:0]        head_raw [NUM_PORTS];
  entry_t               push_entry;
  logic                 push_en;

  logic [0:NUM_TAGS-1]  table_q, table_d;
  logic                 write_valid_q, write_valid_d;
  logic [REG_ADR_W-1:0] write_adr_q, write_adr_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;

  assign port_sel   = in_tag[0 +: PORT_BITS];
  assign tag_idx    = in_tag;
  assign follow_idx = in_follow_branch[1 +: FT];
  assign result     = in_result[1 +: DATA_W];
  assign carry      = in_result[0];
  assign cmd_arith  = is_arith(in_cmd);
  assign cmd_branch = is_branch(in_cmd);
  assign skip       = in_follow_branch[0] && table_q[follow_idx];
  assign taken      = (result == '0);
  assign in_ready   = !fifo_full[port_sel];
  assign accept     = in_valid && in_ready;

  always_comb begin
    push_en       = 1'b0;
    push_entry    = '0;
    table_d       = table_q;
    write_valid_d = 1'b0;
    write_adr_d   = '0;
    write_data_d  = '0;
    if (accept && (cmd_arith || cmd_branch)) begin
      push_en        = 1'b1;
      push_entry.tag = in_tag[PORT_BITS +: TAG_BITS];
      if (skip) begin
        push_entry.resp = RESP_SKIP;
      end else if (cmd_arith) begin
        if (carry) begin
          push_entry.resp = RESP_OVFL;
        end else begin
          push_entry.resp = RESP_OK;
          if (in_result_reg[0]) begin
            write_valid_d = 1'b1;
            write_adr_d   = in_result_reg[1 +: REG_ADR_W];
            write_data_d  = result;
          end
        end
      end else begin
        push_entry.resp = RESP_OK;
        push_entry.data = DATA_W'(taken);
        table_d[tag_idx] = taken;
      end
    end
  end

  always_ff @(negedge c_clk or posedge reset) begin
    if (reset) begin
      table_q       <= '0;
      write_valid_q <= 1'b0;
      write_adr_q   <= '0;
      write_data_q  <= '0;
    end else begin
      table_q       <= table_d;
      write_valid_q <= write_valid_d;
      write_adr_q   <= write_adr_d;
      write_data_q  <= write_data_d;
    end
  end

  assign branch_data = table_q;
  assign write_valid = write_valid_q;
  assign write_adr   = write_adr_q;
  assign write_data  = write_data_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    entry_t head;

    calc_out_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .c_clk     (c_clk),
      .reset     (reset),
      .push      (push_en && (port_sel == PORT_BITS'(p))),
      .push_data (push_entry),
      .pop       (out_ack[p]),
      .full      (fifo_full[p]),
      .valid     (fifo_valid[p]),
      .head      (head_raw[p])
    );

    assign head                            = entry_t'(head_raw[p]);
    assign out_valid[p]                    = fifo_valid[p];
    assign out_resp[p*2 +: 2]              = head.resp;
    assign out_tag[p*TAG_BITS +: TAG_BITS] = head.tag;
    assign out_data[p*DATA_W +: DATA_W]    = head.data;
  end

`ifdef CALC_OUT_OVFL_CNT_EN
  logic [7:0] ovfl_q, ovfl_d;

  always_comb begin
    ovfl_d = ovfl_q;
    if (accept && cmd_arith && !skip && carry && (ovfl_q != 8'hFF))
      ovfl_d = ovfl_q + 8'd1;
  end

  always_ff @(negedge c_clk or posedge reset) begin
    if (reset) ovfl_q <= '0;
    else       ovfl_q <= ovfl_d;
  end

  assign ovfl_count = ovfl_q;
`endif

endmodule

// File: tb/tb_calc_output_stage.sv
// Testbench for calc_output_stage: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the retirement rules.
module tb_calc_output_stage;

  localparam int NP = 4, TB = 2, DW = 32, RW = 4, FD = 2, NT = 16;

  logic          c_clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [0:3]    in_cmd;
  logic [0:3]    in_tag;
  logic [0:32]   in_result;
  logic [0:4]    in_result_reg;
  logic [0:4]    in_follow_branch;
  logic          write_valid;
  logic [0:3]    write_adr;
  logic [0:31]   write_data;
  logic [0:15]   branch_data;
  logic [0:3]    out_valid, out_ack;
  logic [0:7]    out_resp, out_tag;
  logic [0:127]  out_data;
`ifdef CALC_OUT_OVFL_CNT_EN
  logic [0:7]    ovfl_count;
`endif

  always #5 c_clk = ~c_clk;

  calc_output_stage #(
    .NUM_PORTS(NP), .TAG_BITS(TB), .DATA_W(DW), .REG_ADR_W(RW), .FIFO_DEPTH(FD)
  ) dut (
    .c_clk(c_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_tag(in_tag), .in_result(in_result),
    .in_result_reg(in_result_reg), .in_follow_branch(in_follow_branch),
    .write_valid(write_valid), .write_adr(write_adr), .write_data(write_data),
    .branch_data(branch_data), .out_valid(out_valid), .out_ack(out_ack),
    .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data)
`ifdef CALC_OUT_OVFL_CNT_EN
    , .ovfl_count(ovfl_count)
`endif
  );

  // Behavioural model: one queue of responses per port, a bit per branch tag.
  typedef struct { int resp; int tag; int data; } ent_t;
  ent_t        mq [NP][$];
  bit          tbl [NT];
  bit          m_wv;
  int          m_wa;
  logic [31:0] m_wd;
  int          m_ovfl;
  int          n_checks = 0, n_fail = 0;

  function automatic void model_clear();
    for (int p = 0; p < NP; p++) mq[p].delete();
    for (int t = 0; t < NT; t++) tbl[t] = 1'b0;
    m_wv = 1'b0; m_wa = 0; m_wd = '0; m_ovfl = 0;
  endfunction

  function automatic bit model_ready();
    return mq[int'(in_tag) / 4].size() < FD;
  endfunction

  function automatic void model_step();
    int port, tg, c;
    bit acc, carry, skip, tk;
    logic [31:0] rv;
    port  = int'(in_tag) / 4;
    tg    = int'(in_tag) % 4;
    c     = int'(in_cmd);
    acc   = in_valid && (mq[port].size() < FD);
    carry = in_result[0];
    rv    = in_result[1:32];
    skip  = in_follow_branch[0] && tbl[int'(in_follow_branch[1:4])];
    for (int p = 0; p < NP; p++)
      if (out_ack[p] && mq[p].size() > 0) void'(mq[p].pop_front());
    m_wv = 1'b0; m_wa = 0; m_wd = '0;
    if (acc && (c == 1 || c == 2)) begin
      if (skip) mq[port].push_back(ent_t'{3, tg, 0});
      else if (carry) begin
        mq[port].push_back(ent_t'{2, tg, 0});
        if (m_ovfl < 255) m_ovfl++;
      end else begin
        mq[port].push_back(ent_t'{1, tg, 0});
        if (in_result_reg[0]) begin
          m_wv = 1'b1; m_wa = int'(in_result_reg[1:4]); m_wd = rv;
        end
      end
    end else if (acc && (c == 12 || c == 13)) begin
      if (skip) mq[port].push_back(ent_t'{3, tg, 0});
      else begin
        tk = (rv == 0);
        tbl[int'(in_tag)] = tk;
        mq[port].push_back(ent_t'{1, tg, int'(tk)});
      end
    end
  endfunction

  function automatic logic [0:3] one(input int p);
    logic [0:3] a;
    a = '0;
    a[p] = 1'b1;
    return a;
  endfunction

  // Called just after a rising edge; returns just after the next rising edge,
  // with the falling (active) edge in between.
  task automatic drive(input bit v, input logic [3:0] cmd, input logic [3:0] tag,
                       input logic [32:0] res, input logic [4:0] rreg,
                       input logic [4:0] fol, input logic [0:3] ack,
                       output bit rdy_obs, output bit rdy_exp);
    in_valid = v; in_cmd = cmd; in_tag = tag; in_result = res;
    in_result_reg = rreg; in_follow_branch = fol; out_ack = ack;
    #1;
    rdy_obs = in_ready;
    rdy_exp = model_ready();
    @(negedge c_clk);
    model_step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle(input logic [0:3] ack);
    bit ro, re;
    drive(1'b0, 4'h0, 4'h0, '0, '0, '0, ack, ro, re);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_resp !== 8'b0) begin n_fail++; $display("FAIL rst_out_resp: got %h want 0", out_resp); end
    n_checks++; if (out_tag !== 8'b0) begin n_fail++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
    n_checks++; if (out_data !== 128'b0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL rst_write_valid: got %b want 0", write_valid); end
    n_checks++; if (write_adr !== 4'b0 || write_data !== 32'b0) begin n_fail++; $display("FAIL rst_write_bus: got %h/%h want 0/0", write_adr, write_data); end
    n_checks++; if (branch_data !== 16'b0) begin n_fail++; $display("FAIL rst_branch_data: got %h want 0", branch_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(posedge c_clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_add_write();
    bit ro, re;
    drive(1'b1, 4'h1, 4'h5, {1'b0, 32'h7}, 5'b1_0011, 5'b0, 4'b0000, ro, re);
    n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", ro); end
    n_checks++; if (write_valid !== 1'b1) begin n_fail++; $display("FAIL add_write_valid: got %b want 1", write_valid); end
    n_checks++; if (write_adr !== 4'd3) begin n_fail++; $display("FAIL add_write_adr: got %h want 3", write_adr); end
    n_checks++; if (write_data !== 32'h7) begin n_fail++; $display("FAIL add_write_data: got %h want 7", write_data); end
    n_checks++; if (out_valid[1] !== 1'b1 || out_resp[2:3] !== 2'b01) begin n_fail++; $display("FAIL add_resp: got v=%b r=%b want v=1 r=01", out_valid[1], out_resp[2:3]); end
    n_checks++; if (out_tag[2:3] !== 2'b01 || out_data[32:63] !== 32'h0) begin n_fail++; $display("FAIL add_tag_data: got %b/%h want 01/0", out_tag[2:3], out_data[32:63]); end
    idle(one(1));
    n_checks++; if (write_valid !== 1'b0 || write_adr !== 4'b0 || write_data !== 32'b0) begin n_fail++; $display("FAIL add_write_clear: got %b/%h/%h want 0/0/0", write_valid, write_adr, write_data); end
    n_checks++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL add_pop: got %b want 0", out_valid[1]); end
  endtask

  task automatic test_sub_overflow();
    bit ro, re;
    drive(1'b1, 4'h2, 4'h2, {1'b1, 32'h5}, 5'b1_0001, 5'b0, 4'b0000, ro, re);
    n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL sub_no_write: got %b want 0", write_valid); end
    n_checks++; if (out_valid[0] !== 1'b1 || out_resp[0:1] !== 2'b10 || out_tag[0:1] !== 2'b10) begin n_fail++; $display("FAIL sub_resp: got v=%b r=%b t=%b want 1/10/10", out_valid[0], out_resp[0:1], out_tag[0:1]); end
`ifdef CALC_OUT_OVFL_CNT_EN
    n_checks++; if (ovfl_count !== 8'd1) begin n_fail++; $display("FAIL sub_ovfl_count: got %0d want 1", ovfl_count); end
`endif
    idle(one(0));
  endtask

  task automatic test_branch_skip();
    bit ro, re;
    drive(1'b1, 4'hC, 4'h9, {1'b0, 32'h0}, 5'b1_0010, 5'b0, 4'b0000, ro, re);
    n_checks++; if (branch_data[9] !== 1'b1) begin n_fail++; $display("FAIL br_taken_table: got %b want 1", branch_data[9]); end
    n_checks++; if (out_valid[2] !== 1'b1 || out_resp[4:5] !== 2'b01 || out_data[64:95] !== 32'h1) begin n_fail++; $display("FAIL br_taken_resp: got %b/%b/%h want 1/01/1", out_valid[2], out_resp[4:5], out_data[64:95]); end
    n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL br_no_write: got %b want 0", write_valid); end
    drive(1'b1, 4'h1, 4'h4, {1'b0, 32'h9}, 5'b1_0101, 5'b1_1001, one(2), ro, re);
    n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL skip_no_write: got %b want 0", write_valid); end
    n_checks++; if (out_resp[2:3] !== 2'b11 || out_data[32:63] !== 32'h0) begin n_fail++; $display("FAIL skip_resp: got %b/%h want 11/0", out_resp[2:3], out_data[32:63]); end
    drive(1'b1, 4'h1, 4'h4, {1'b0, 32'h9}, 5'b1_0101, 5'b0_1001, one(1), ro, re);
    n_checks++; if (write_valid !== 1'b1 || write_adr !== 4'd5 || write_data !== 32'h9) begin n_fail++; $display("FAIL noflag_write: got %b/%h/%h want 1/5/9", write_valid, write_adr, write_data); end
    drive(1'b1, 4'hD, 4'h9, {1'b0, 32'h5}, 5'b0, 5'b0, one(1), ro, re);
    n_checks++; if (branch_data[9] !== 1'b0) begin n_fail++; $display("FAIL br_not_taken_table: got %b want 0", branch_data[9]); end
    n_checks++; if (out_resp[4:5] !== 2'b01 || out_data[64:95] !== 32'h0) begin n_fail++; $display("FAIL br_not_taken_resp: got %b/%h want 01/0", out_resp[4:5], out_data[64:95]); end
    idle(4'b1111); idle(4'b1111);
  endtask

  task automatic test_backpressure();
    bit ro, re;
    drive(1'b1, 4'h1, 4'hC, '0, 5'b0, 5'b0, 4'b0000, ro, re);
    n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", ro); end
    drive(1'b1, 4'h1, 4'hC, '0, 5'b0, 5'b0, 4'b0000, ro, re);
    n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL bp_ready2: got %b want 1", ro); end
    drive(1'b1, 4'h1, 4'hC, '0, 5'b0, 5'b0, 4'b0000, ro, re);
    n_checks++; if (ro !== 1'b0) begin n_fail++; $display("FAIL bp_ready3_full: got %b want 0", ro); end
    drive(1'b1, 4'h1, 4'hC, '0, 5'b0, 5'b0, one(3), ro, re);
    n_checks++; if (ro !== 1'b0) begin n_fail++; $display("FAIL bp_no_passthrough: got %b want 0", ro); end
    drive(1'b1, 4'h1, 4'hC, '0, 5'b0, 5'b0, 4'b0000, ro, re);
    n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_ack: got %b want 1", ro); end
    idle(one(3));
    n_checks++; if (out_valid[3] !== 1'b1) begin n_fail++; $display("FAIL bp_second_entry: got %b want 1", out_valid[3]); end
    idle(one(3));
    n_checks++; if (out_valid[3] !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid[3]); end
  endtask

  task automatic test_invalid();
    bit ro, re;
    drive(1'b1, 4'hC, 4'h3, {1'b0, 32'h0}, 5'b0, 5'b0, 4'b1111, ro, re);
    drive(1'b1, 4'h7, 4'h3, {1'b0, 32'h1234}, 5'b1_1111, 5'b0, one(0), ro, re);
    n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL inv_no_write: got %b want 0", write_valid); end
    n_checks++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL inv_no_resp: got %b want 0", out_valid[0]); end
    n_checks++; if (branch_data[3] !== 1'b1) begin n_fail++; $display("FAIL inv_table_kept: got %b want 1", branch_data[3]); end
  endtask

  task automatic test_reset_midflight();
    bit ro, re;
    idle(4'b1111); idle(4'b1111);
    drive(1'b1, 4'h1, 4'h0, {1'b0, 32'hA}, 5'b1_0001, 5'b0, 4'b0000, ro, re);
    drive(1'b1, 4'h1, 4'h1, {1'b0, 32'hB}, 5'b1_0010, 5'b0, 4'b0000, ro, re);
    n_checks++; if (out_valid[0] !== 1'b1 || write_valid !== 1'b1) begin n_fail++; $display("FAIL mid_precond: got v=%b w=%b want 1/1", out_valid[0], write_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 4'b0 || out_resp !== 8'b0 || out_tag !== 8'b0 || out_data !== 128'b0) begin n_fail++; $display("FAIL mid_out_clear: got %b/%h/%h want 0", out_valid, out_resp, out_tag); end
    n_checks++; if (write_valid !== 1'b0 || write_adr !== 4'b0 || write_data !== 32'b0) begin n_fail++; $display("FAIL mid_write_clear: got %b/%h/%h want 0", write_valid, write_adr, write_data); end
    n_checks++; if (branch_data !== 16'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_table_ready: got %h/%b want 0/1", branch_data, in_ready); end
    @(negedge c_clk); #1;
    n_checks++; if (out_valid !== 4'b0 || write_valid !== 1'b0) begin n_fail++; $display("FAIL mid_held: got %b/%b want 0/0", out_valid, write_valid); end
    @(posedge c_clk); #1;
    in_valid = 1'b0; out_ack = '0;
    reset = 1'b0;
    model_clear();
  endtask

`ifdef CALC_OUT_OVFL_CNT_EN
  task automatic test_ovfl_saturate();
    bit ro, re;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 4'h2, 4'h0, {1'b1, 32'h1}, 5'b0, 5'b0, one(0), ro, re);
      n_checks++; if (ovfl_count !== 8'(m_ovfl)) begin n_fail++; $display("FAIL ovfl_count[%0d]: got %0d want %0d", i, ovfl_count, m_ovfl); end
    end
    n_checks++; if (ovfl_count !== 8'd255) begin n_fail++; $display("FAIL ovfl_saturated: got %0d want 255", ovfl_count); end
    idle(4'b1111);
  endtask
`endif

  task automatic test_random();
    bit ro, re, v;
    logic [3:0] cmd;
    logic [31:0] rv;
    logic [0:15] exp_bd;
    int r, er, et, ed;
    bit ev;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 3) ? 4'h1 : (r < 5) ? 4'h2 : (r < 7) ? 4'hC : (r == 7) ? 4'hD : 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      v = ($urandom_range(0, 4) != 0);
      drive(v, cmd, 4'($urandom_range(0, 15)), {($urandom_range(0, 3) == 0), rv},
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            4'($urandom_range(0, 15)), ro, re);
      n_checks++; if (ro !== re) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, ro, re); end
      n_checks++; if (write_valid !== m_wv || write_adr !== 4'(m_wa) || write_data !== m_wd) begin n_fail++; $display("FAIL rnd_write[%0d]: got %b/%h/%h want %b/%h/%h", cyc, write_valid, write_adr, write_data, m_wv, m_wa, m_wd); end
      for (int t = 0; t < NT; t++) exp_bd[t] = tbl[t];
      n_checks++; if (branch_data !== exp_bd) begin n_fail++; $display("FAIL rnd_branch_data[%0d]: got %h want %h", cyc, branch_data, exp_bd); end
      for (int p = 0; p < NP; p++) begin
        ev = mq[p].size() > 0;
        er = ev ? mq[p][0].resp : 0;
        et = ev ? mq[p][0].tag  : 0;
        ed = ev ? mq[p][0].data : 0;
        n_checks++;
        if (out_valid[p] !== ev || out_resp[p*2 +: 2] !== 2'(er) || out_tag[p*2 +: 2] !== 2'(et) || out_data[p*32 +: 32] !== 32'(ed)) begin
          n_fail++;
          $display("FAIL rnd_port%0d[%0d]: got v=%b r=%b t=%b d=%h want v=%b r=%0d t=%0d d=%0d", p, cyc, out_valid[p], out_resp[p*2 +: 2], out_tag[p*2 +: 2], out_data[p*32 +: 32], ev, er, et, ed);
        end
      end
`ifdef CALC_OUT_OVFL_CNT_EN
      n_checks++; if (ovfl_count !== 8'(m_ovfl)) begin n_fail++; $display("FAIL rnd_ovfl[%0d]: got %0d want %0d", cyc, ovfl_count, m_ovfl); end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_cmd = '0; in_tag = '0; in_result = '0;
    in_result_reg = '0; in_follow_branch = '0; out_ack = '0;
    model_clear();
    #1;
    test_reset();
    test_add_write();
    test_sub_overflow();
    test_branch_skip();
    test_backpressure();
    test_invalid();
    test_reset_midflight();
`ifdef CALC_OUT_OVFL_CNT_EN
    test_ovfl_saturate();
`endif
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_output_stage.md
# calc_output_stage

Parametrised result-retirement stage for the calc3 datapath. Accepts one completed ALU command per cycle and classifies it as add/sub, branch, skipped or invalid. It updates the branch-condition table and issues the register-file write. Responses are queued in per-port FIFOs with a valid/ack handshake, so requesters can stall without losing results.

## Interface
Parameters:
- NUM_PORTS, 4, requester ports (power of 2, ≥2); PORT_BITS = log2(NUM_PORTS)
- TAG_BITS, 2, per-port tag width; full tag FT = PORT_BITS+TAG_BITS; NUM_TAGS = 2^FT
- DATA_W, 32, operand/result width
- REG_ADR_W, 4, register-file address width
- FIFO_DEPTH, 2, response entries per port (power of 2, ≥2)

Ports (all vectors [0:N-1], MSB at index 0):
- c_clk  in  1  sole clock; all state updates on its negedge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  command presented
- in_ready  out  1  command accepted when in_valid && in_ready
- in_cmd  in  4  command code
- in_tag  in  FT  [0:PORT_BITS-1] = port, remainder = tag
- in_result  in  DATA_W+1  [0] = carry/borrow, [1:DATA_W] = result
- in_result_reg  in  1+REG_ADR_W  [0] = write enable, rest = address
- in_follow_branch  in  1+FT  [0] = dependent flag, rest = tag of the governing branch
- write_valid / write_adr / write_data  out  1 / REG_ADR_W / DATA_W  register-file write
- branch_data  out  NUM_TAGS  branch table, entry t at index t
- out_valid, out_ack  out/in  NUM_PORTS  per-port handshake
- out_resp / out_tag / out_data  out  2·NUM_PORTS / TAG_BITS·NUM_PORTS / DATA_W·NUM_PORTS  port p occupies slice p·W … (p+1)·W−1

## Operation
- Commands: 0001 add, 0010 sub, 1100 and 1101 branch. Any other code is accepted, produces no response and no write, and leaves the table unchanged.
- Responses: 01 success, 10 overflow, 11 skipped.
- skip = in_follow_branch[0] && branch_table[follow tag].
  - Skipped command: response 11, data 0, no write, no table update.
- Add/sub, not skipped:
  - If in_result[0]=1: response 10, no write.
  - Otherwise: response 01, data 0, and a write when in_result_reg[0]=1.
- Branch, not skipped:
  - taken = (in_result[1:DATA_W]==0).
  - branch_table[in_tag] <= taken.
  - Response 01, data = taken ? 1 : 0, no write.
- Responses push into FIFO[in_tag port] together with the tag bits.
- A port pops on out_valid && out_ack. Each port shows its FIFO head.
- in_ready = FIFO[in_tag port] not full, where "full" is evaluated before any same-cycle pop (no pass-through).
- Push and pop on the same edge of a non-full, non-empty FIFO keeps its occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Register write: write_valid/adr/data are registered and valid one c_clk after acceptance. Each is 0 in any cycle without a write.
- Table update is visible on branch_data and to the next accepted command's skip check one cycle after acceptance.
- Response: out_valid rises one cycle after the push into an empty FIFO. It stays high with stable resp/tag/data until acked.
- Throughput: one command per cycle per port while not full.
- Reset, asserted at any time: immediately clears all FIFOs, the table and the write registers.
  - Outputs: out_valid=0, resp/tag/data=0, write_*=0, branch_data=0.
  - in_ready=1.
  - In-flight commands are discarded.

## Configuration
- CALC_OUT_OVFL_CNT_EN defined: adds output ovfl_count[0:7].
  - Increments on each accepted overflow (response 10) and saturates at 255.
  - Reset to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package calc3_pkg holds:
  - command encodings (CMD_ADD, CMD_SUB, CMD_BZ, CMD_BEQ)
  - response codes (RESP_NONE, RESP_OK, RESP_OVFL, RESP_SKIP)
  - response-entry struct {resp, tag, data}
- Sub-module calc_out_fifo: one synchronous FIFO of width 2+TAG_BITS+DATA_W and depth FIFO_DEPTH, instantiated NUM_PORTS times.

## Test plan
- Add to tag 0x5 with result 0x0000_0007, carry 0, result_reg 1_0011 → next cycle write_valid=1, adr=3, data=7; port 1 out_resp=01, out_tag=01, out_data=0.
- Sub to tag 0x2 with carry 1 → no write; port 0 resp=10; ovfl_count increments (macro defined).
- Branch to tag 0x9 with result 0 → branch_data[9]=1, port 2 data=1. A following add with follow_branch=1_1001 → resp 11, no write.
- Port 3, out_ack=0, FIFO_DEPTH=2, three tag-0xC commands on consecutive cycles → in_ready=0 on the third. Ack the head → the third command is accepted next cycle.
- Reset asserted while port 0 holds two entries and a write is pending → all outputs 0 without waiting for a clock edge; in_ready=1.
- Invalid cmd 0111 with write enable set → no write, no response, table unchanged.
